// File: rtl/plot_arbiter_if.sv
// Pixel-write sharing bus: client rectangle descriptors in, arbitration
// handshake and vga_adapter pixel stream out.
interface plot_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] rect_x;
  logic [8*NUM_REQ-1:0] rect_y;
  logic [8*NUM_REQ-1:0] rect_w;
  logic [8*NUM_REQ-1:0] rect_h;
  logic [3*NUM_REQ-1:0] rect_colour;
  logic [NUM_REQ-1:0]   ack;
  logic [NUM_REQ-1:0]   done;
  logic                 busy;
  logic [7:0]           x;
  logic [7:0]           y;
  logic [2:0]           colour;
  logic                 plot;

  modport master (
    output req, rect_x, rect_y, rect_w, rect_h, rect_colour,
    input  ack, done, busy, x, y, colour, plot
  );

  modport slave (
    input  req, rect_x, rect_y, rect_w, rect_h, rect_colour,
    output ack, done, busy, x, y, colour, plot
  );
endinterface

// File: rtl/plot_arbiter.sv
// Round-robin arbiter that shares the vga_adapter pixel port among
// NUM_REQ clients and rasterises each granted filled rectangle at one
// pixel per clock, suppressing pixels outside H_RES x V_RES.
module plot_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned H_RES   = 160,
  parameter int unsigned V_RES   = 120
) (
  input logic           clk,
  input logic           resetn,
  plot_arbiter_if.slave bus
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRAW   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]         r_state;
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      r_gnt;
  logic [7:0]         r_rx, r_ry, r_rw, r_rh;
  logic [2:0]         r_col;
  logic [7:0]         r_cx, r_cy;
  logic [NUM_REQ-1:0] r_ack, r_done;
  logic               r_busy;
  logic [7:0]         r_x, r_y;
  logic [2:0]         r_colour;
  logic               r_plot;

  logic               w_any;
  logic [PW-1:0]      w_gnt;
  int unsigned        w_idx;
  logic [7:0]         w_sel_x, w_sel_y, w_sel_w, w_sel_h;
  logic [2:0]         w_sel_col;
  logic [8:0]         w_sx, w_sy;
  logic               w_vis;
  logic               w_end_x, w_end_y;

  // Round-robin pick: first set request above the pointer, wrapping.
  // Scanning from the far end lets the nearest candidate win last.
  always_comb begin
    w_any = 1'b0;
    w_gnt = r_ptr;
    w_idx = 0;
    for (int unsigned i = NUM_REQ; i >= 1; i--) begin
      w_idx = (32'(r_ptr) + i) % NUM_REQ;
      if ((bus.req & (NUM_REQ'(1) << w_idx)) != '0) begin
        w_any = 1'b1;
        w_gnt = PW'(w_idx);
      end
    end
  end

  // Descriptor fields of the candidate client and current pixel geometry.
  always_comb begin
    w_sel_x   = 8'(bus.rect_x >> (32'(w_gnt) * 32'd8));
    w_sel_y   = 8'(bus.rect_y >> (32'(w_gnt) * 32'd8));
    w_sel_w   = 8'(bus.rect_w >> (32'(w_gnt) * 32'd8));
    w_sel_h   = 8'(bus.rect_h >> (32'(w_gnt) * 32'd8));
    w_sel_col = 3'(bus.rect_colour >> (32'(w_gnt) * 32'd3));
    w_sx      = {1'b0, r_rx} + {1'b0, r_cx};
    w_sy      = {1'b0, r_ry} + {1'b0, r_cy};
    w_vis     = (32'(w_sx) < H_RES) && (32'(w_sy) < V_RES);
    w_end_x   = (r_cx == r_rw - 8'd1);
    w_end_y   = (r_cy == r_rh - 8'd1);
  end

  // Grant / raster / finish sequencer with registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_ptr    <= PW'(NUM_REQ - 1);
      r_gnt    <= '0;
      r_rx     <= '0;
      r_ry     <= '0;
      r_rw     <= '0;
      r_rh     <= '0;
      r_col    <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_ack    <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
    end else begin
      r_ack  <= '0;
      r_done <= '0;
      r_plot <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_ptr <= w_gnt;
            r_gnt <= w_gnt;
            r_rx  <= w_sel_x;
            r_ry  <= w_sel_y;
            r_rw  <= w_sel_w;
            r_rh  <= w_sel_h;
            r_col <= w_sel_col;
            r_cx  <= '0;
            r_cy  <= '0;
            r_ack <= NUM_REQ'(1) << w_gnt;
            r_busy <= 1'b1;
            if ((w_sel_w == 8'd0) || (w_sel_h == 8'd0)) begin
              r_state <= S_FINISH;
            end else begin
              r_state <= S_DRAW;
            end
          end
        end
        S_DRAW: begin
          r_x      <= w_sx[7:0];
          r_y      <= w_sy[7:0];
          r_colour <= r_col;
          r_plot   <= w_vis;
          if (w_end_x) begin
            r_cx <= '0;
            r_cy <= r_cy + 8'd1;
            if (w_end_y) begin
              r_state <= S_FINISH;
            end
          end else begin
            r_cx <= r_cx + 8'd1;
          end
        end
        S_FINISH: begin
          r_done  <= NUM_REQ'(1) << r_gnt;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack    = r_ack;
  assign bus.done   = r_done;
  assign bus.busy   = r_busy;
  assign bus.x      = r_x;
  assign bus.y      = r_y;
  assign bus.colour = r_colour;
  assign bus.plot   = r_plot;

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter: raster order, round-robin, clipping,
// empty rectangles, full-screen clear and asynchronous abort.
module tb_plot_arbiter;

  logic clk;
  logic resetn;
  int unsigned n_checks;
  int unsigned n_fail;

  plot_arbiter_if #(.NUM_REQ(4)) bus ();

  plot_arbiter #(
    .NUM_REQ(4),
    .H_RES  (160),
    .V_RES  (120)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input int c, input int x, input int y, input int w,
                          input int h, input int col);
    bus.rect_x[8*c +: 8]      = 8'(x);
    bus.rect_y[8*c +: 8]      = 8'(y);
    bus.rect_w[8*c +: 8]      = 8'(w);
    bus.rect_h[8*c +: 8]      = 8'(h);
    bus.rect_colour[3*c +: 3] = 3'(col);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  // Single-client rectangle with a per-pixel expectation model.
  task automatic rect(input int c, input int x, input int y, input int w,
                      input int h, input int col, input int exp_plots);
    int n;
    int sx, sy;
    logic ep;
    set_desc(c, x, y, w, h, col);
    bus.req = 4'(1 << c);
    tick();
    check("ack", bus.ack, 32'(1 << c));
    check("busy_on", bus.busy, 1);
    check("plot_at_ack", bus.plot, 0);
    bus.req = '0;
    set_desc(c, 8'hAA, 8'h55, 8'h03, 8'h03, 3'(~col));
    n = 0;
    for (int i = 0; i < w * h; i++) begin
      tick();
      sx = x + (i % w);
      sy = y + (i / w);
      ep = (sx < 160) && (sy < 120);
      check("plot", bus.plot, 32'(ep));
      check("px", bus.x, 32'(sx & 255));
      check("py", bus.y, 32'(sy & 255));
      check("colour", bus.colour, 32'(col));
      check("done_early", bus.done, 0);
      if (bus.plot === 1'b1) n++;
    end
    tick();
    check("done", bus.done, 32'(1 << c));
    check("plot_at_done", bus.plot, 0);
    check("busy_off", bus.busy, 0);
    check("nplots", n, exp_plots);
  endtask

  // Two simultaneous 1x1 requests; checks service order.
  task automatic pair(input int a, input int b, input int first, input int second);
    set_desc(a, 4, 4, 1, 1, a);
    set_desc(b, 6, 6, 1, 1, b);
    bus.req = 4'((1 << a) | (1 << b));
    tick();
    check("pair_ack1", bus.ack, 32'(1 << first));
    bus.req = 4'(1 << second);
    tick();
    check("pair_plot1", bus.plot, 1);
    tick();
    check("pair_done1", bus.done, 32'(1 << first));
    tick();
    check("pair_ack2", bus.ack, 32'(1 << second));
    bus.req = '0;
    tick();
    check("pair_plot2", bus.plot, 1);
    tick();
    check("pair_done2", bus.done, 32'(1 << second));
  endtask

  initial begin
    int seen;
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    bus.req  = '0;
    bus.rect_x = '0;
    bus.rect_y = '0;
    bus.rect_w = '0;
    bus.rect_h = '0;
    bus.rect_colour = '0;
    tick();
    tick();
    check("rst_ack", bus.ack, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_x", bus.x, 0);
    check("rst_y", bus.y, 0);
    check("rst_colour", bus.colour, 0);
    check("rst_plot", bus.plot, 0);
    resetn = 1'b1;
    tick();
    check("idle_plot", bus.plot, 0);

    // 2x2 at (10,20) colour 7 from client 1
    rect(1, 10, 20, 2, 2, 7, 4);
    tick();
    check("idle_done_clear", bus.done, 0);

    // round-robin from a fresh pointer
    do_reset();
    pair(0, 2, 0, 2);
    pair(0, 2, 0, 2);
    rect(0, 1, 1, 1, 1, 3, 1);
    pair(2, 3, 2, 3);

    // clipping at the bottom-right corner
    rect(3, 158, 119, 4, 2, 5, 2);
    // empty rectangle
    rect(2, 30, 30, 0, 5, 1, 0);
    // x wrap beyond 255 in the 9-bit sum is suppressed
    rect(1, 250, 10, 8, 1, 2, 0);
    // full-screen clear
    rect(0, 0, 0, 160, 120, 0, 19200);

    // asynchronous abort mid-draw
    set_desc(0, 0, 0, 16, 2, 5);
    bus.req = 4'b0001;
    tick();
    check("abort_ack", bus.ack, 1);
    bus.req = '0;
    repeat (5) tick();
    check("abort_pix5_plot", bus.plot, 1);
    check("abort_pix5_x", bus.x, 4);
    #2 resetn = 1'b0;
    #1;
    check("abort_plot", bus.plot, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_ack0", bus.ack, 0);
    check("abort_done0", bus.done, 0);
    #2 resetn = 1'b1;
    seen = 0;
    repeat (3) begin
      tick();
      if (bus.done !== 4'b0000 || bus.busy !== 1'b0) seen++;
    end
    check("abort_quiet", seen, 0);
    bus.req = 4'b0011;
    tick();
    check("abort_regrant", bus.ack, 1);
    bus.req = 4'b0010;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.done == 4'b0001) begin
        seen = 1;
        break;
      end
    end
    check("abort_regrant_done", seen, 1);
    tick();
    check("next_ack_c1", bus.ack, 2);
    bus.req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
